// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory port arbiter: read latency, the
// in-flight read tag carried down the return pipe, and a one-hot decoder.
package mem_arb_pkg;

  localparam int RD_LAT   = 2;
  localparam int MAX_NREQ = 4;
  // Tag id is sized for the largest supported requester count.
  localparam int ID_W     = 2;

  typedef struct packed {
    logic            v;
    logic [ID_W-1:0] id;
  } rd_tag_t;

  function automatic logic [MAX_NREQ-1:0] onehot(input logic [ID_W-1:0] id);
    logic [MAX_NREQ-1:0] r;
    r     = '0;
    r[id] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester found when the
// search starts at ptr and wraps modulo NREQ.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0] valid,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt_onehot,
  output logic [ID_W-1:0] gnt_id,
  output logic            any
);

  logic [MAX_NREQ-1:0] valid_ext;
  logic [MAX_NREQ-1:0] oh_ext;
  logic [ID_W-1:0]     idx;

  assign valid_ext = MAX_NREQ'(valid);

  always_comb begin
    any    = 1'b0;
    gnt_id = '0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % NREQ);
      if (!any && valid_ext[idx]) begin
        any    = 1'b1;
        gnt_id = idx;
      end
    end
  end

  assign oh_ext     = onehot(gnt_id);
  assign gnt_onehot = any ? oh_ext[NREQ-1:0] : '0;

endmodule

// File: rtl/mem_port_arb.sv
// Round-robin arbiter sharing memory read port 1 and the write port among
// NREQ requesters; reads return RD_LAT cycles later tagged to their issuer.
module mem_port_arb
  import mem_arb_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  input  logic [NREQ-1:0]        req_kill,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_data,
  output logic [1:0]             rd_inflight,
  output logic [ADDR_W-1:0]      mem_raddr,
  input  logic [DATA_W-1:0]      mem_rdata,
  output logic                   mem_wen,
  output logic [ADDR_W-1:0]      mem_waddr,
  output logic [DATA_W-1:0]      mem_wdata
);

  logic [ID_W-1:0]             ptr_reg, ptr_next;
  rd_tag_t [RD_LAT-1:0]        pipe_reg, pipe_next;
  logic [NREQ-1:0]             gnt_onehot;
  logic [ID_W-1:0]             gnt_id;
  logic                        gnt_any;
  logic                        accept;
  logic                        gnt_we;
  logic [ADDR_W-1:0]           gnt_addr;
  logic [DATA_W-1:0]           gnt_wdata;
  logic [MAX_NREQ-1:0]         we_ext, kill_ext, rsp_oh;
  logic [ADDR_W-1:0]           addr_arr  [MAX_NREQ];
  logic [DATA_W-1:0]           wdata_arr [MAX_NREQ];

  // Unpack the flat request buses into arrays indexable by any tag id.
  for (genvar gi = 0; gi < MAX_NREQ; gi++) begin : g_unpack
    if (gi < NREQ) begin : g_live
      assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
      assign we_ext[gi]    = req_we[gi];
      assign kill_ext[gi]  = req_kill[gi];
    end else begin : g_pad
      assign addr_arr[gi]  = '0;
      assign wdata_arr[gi] = '0;
      assign we_ext[gi]    = 1'b0;
      assign kill_ext[gi]  = 1'b0;
    end
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .valid      (req_valid),
    .ptr        (ptr_reg),
    .gnt_onehot (gnt_onehot),
    .gnt_id     (gnt_id),
    .any        (gnt_any)
  );

  assign accept    = gnt_any & rst_n;
  assign req_ready = rst_n ? gnt_onehot : '0;
  assign gnt_we    = we_ext[gnt_id];
  assign gnt_addr  = addr_arr[gnt_id];
  assign gnt_wdata = wdata_arr[gnt_id];

  assign mem_wen   = accept & gnt_we;
  assign mem_waddr = gnt_addr;
  assign mem_wdata = gnt_wdata;
  assign mem_raddr = (accept && !gnt_we) ? gnt_addr : '0;

  always_comb begin
    ptr_next = ptr_reg;
    if (accept) begin
      ptr_next = (gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + ID_W'(1);
    end
  end

  // A kill in cycle K drops the read accepted in K and every older tag of
  // that requester still waiting; the tag presenting its response now is
  // leaving the pipe anyway and keeps its strobe.
  always_comb begin
    pipe_next       = pipe_reg;
    pipe_next[0].v  = accept & ~gnt_we & ~kill_ext[gnt_id];
    pipe_next[0].id = gnt_id;
    for (int s = 1; s < RD_LAT; s++) begin
      pipe_next[s]   = pipe_reg[s-1];
      pipe_next[s].v = pipe_reg[s-1].v & ~kill_ext[pipe_reg[s-1].id];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_reg  <= '0;
      pipe_reg <= '0;
    end else begin
      ptr_reg  <= ptr_next;
      pipe_reg <= pipe_next;
    end
  end

  assign rsp_oh    = onehot(pipe_reg[RD_LAT-1].id);
  assign rsp_valid = pipe_reg[RD_LAT-1].v ? rsp_oh[NREQ-1:0] : '0;
  assign rsp_data  = mem_rdata;

  always_comb begin
    rd_inflight = '0;
    for (int s = 0; s < RD_LAT; s++) begin
      rd_inflight = rd_inflight + 2'(pipe_reg[s].v);
    end
  end

endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: directed scenarios plus a randomized run checked
// against a queue-based model of grants, memory contents and response timing.
module tb_mem_port_arb;

  localparam int NREQ   = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic                   clk;
  logic                   rst_n;
  logic [NREQ-1:0]        req_valid, req_ready, req_we, req_kill, rsp_valid;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0]      rsp_data, mem_rdata, mem_wdata;
  logic [1:0]             rd_inflight;
  logic [ADDR_W-1:0]      mem_raddr, mem_waddr;
  logic                   mem_wen;

  int checks = 0;
  int errors = 0;

  mem_port_arb #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_kill    (req_kill),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rd_inflight (rd_inflight),
    .mem_raddr   (mem_raddr),
    .mem_rdata   (mem_rdata),
    .mem_wen     (mem_wen),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory with a two-cycle registered read, word index from addr[9:2].
  logic [31:0] mem [256];
  logic [31:0] rd_p1;
  logic        mem_init, poke;
  logic [7:0]  poke_idx;
  logic [31:0] poke_val, salt;

  function automatic logic [31:0] fill(input int i, input logic [31:0] s);
    return 32'hC0DE0000 ^ (32'(i) * 32'h9E3779B1) ^ s;
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= fill(i, salt);
    end else if (poke) begin
      mem[poke_idx] <= poke_val;
    end else if (mem_wen) begin
      mem[mem_waddr[9:2]] <= mem_wdata;
    end
    rd_p1     <= mem[mem_raddr[9:2]];
    mem_rdata <= rd_p1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
    req_valid[i]           = v;
    req_we[i]              = we;
    req_addr[i*32 +: 32]   = a;
    req_wdata[i*32 +: 32]  = d;
  endtask

  task automatic drive_idle();
    req_valid = '0;
    req_we    = '0;
    req_kill  = '0;
  endtask

  function automatic int pick(input logic [1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (p + k) % NREQ;
      if (((v >> j) & 2'b01) != 2'b00) return j;
    end
    return -1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    set_req(0, 1'b1, 1'b1, 32'h3FC, 32'h0);
    set_req(1, 1'b1, 1'b1, 32'h3FC, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (req_ready !== 2'b00) $display("FAIL rst_ready: got %b expected 00", req_ready);
      checks++; if (mem_wen !== 1'b0) $display("FAIL rst_wen: got %b expected 0", mem_wen);
      checks++; if (rsp_valid !== 2'b00) $display("FAIL rst_rsp: got %b expected 00", rsp_valid);
      if (req_ready !== 2'b00 || mem_wen !== 1'b0 || rsp_valid !== 2'b00) errors++;
    end
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    mem_init = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL rst_first_grant: got %b expected 01", req_ready);
    end
    $display("reset: first grant %b", req_ready);
    tick();
    drive_idle();
  endtask

  task automatic test_read_latency();
    poke_idx = 8'd4; poke_val = 32'hDEADBEEF; poke = 1'b1;
    tick();
    poke = 1'b0;
    set_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rd_ready: got %b expected 01", req_ready); end
    checks++; if (mem_raddr !== 32'h10) begin errors++; $display("FAIL rd_raddr: got %h expected 00000010", mem_raddr); end
    checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL rd_wen: got %b expected 0", mem_wen); end
    tick();
    drive_idle();
    @(negedge clk);
    checks++; if (rd_inflight !== 2'd1) begin errors++; $display("FAIL rd_inflight_t1: got %0d expected 1", rd_inflight); end
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rd_rsp_t1: got %b expected 00", rsp_valid); end
    tick();
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL rd_rsp_t2: got %b expected 01", rsp_valid); end
    checks++; if (rsp_data !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data_t2: got %h expected deadbeef", rsp_data); end
    $display("read 0x10: rsp_valid=%b data=%h", rsp_valid, rsp_data);
    tick();
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rd_rsp_t3: got %b expected 00", rsp_valid); end
    checks++; if (rd_inflight !== 2'd0) begin errors++; $display("FAIL rd_inflight_t3: got %0d expected 0", rd_inflight); end
    tick();
  endtask

  task automatic test_alternate();
    int          gh [10];
    logic [31:0] ah [10];
    logic [1:0]  exp_rdy, exp_rsp;
    int          w0, w1;
    w0 = 16; w1 = 32;
    for (int k = 0; k < 10; k++) begin
      if (k < 8) begin
        set_req(0, 1'b1, 1'b0, 32'(w0 * 4), 32'h0);
        set_req(1, 1'b1, 1'b0, 32'(w1 * 4), 32'h0);
      end else begin
        drive_idle();
      end
      @(negedge clk);
      if (k < 8) begin
        // req0 was granted last, so the rotation starts at req1.
        gh[k]   = (k % 2 == 0) ? 1 : 0;
        ah[k]   = (gh[k] == 1) ? 32'(w1 * 4) : 32'(w0 * 4);
        exp_rdy = 2'b01 << gh[k];
        checks++;
        if (req_ready !== exp_rdy) begin
          errors++; $display("FAIL alt_grant[%0d]: got %b expected %b", k, req_ready, exp_rdy);
        end
        $display("alt %0d: grant %b addr %h", k, req_ready, ah[k]);
      end
      if (k >= 2) begin
        exp_rsp = 2'b01 << gh[k-2];
        checks++;
        if (rsp_valid !== exp_rsp) begin
          errors++; $display("FAIL alt_rsp[%0d]: got %b expected %b", k, rsp_valid, exp_rsp);
        end
        checks++;
        if (rsp_data !== fill(int'(ah[k-2][9:2]), 32'h0)) begin
          errors++; $display("FAIL alt_data[%0d]: got %h expected %h", k, rsp_data, fill(int'(ah[k-2][9:2]), 32'h0));
        end
      end
      if (k >= 2 && k < 8) begin
        checks++;
        if (rd_inflight !== 2'd2) begin
          errors++; $display("FAIL alt_inflight[%0d]: got %0d expected 2", k, rd_inflight);
        end
      end
      tick();
      if (k < 8) begin
        if (gh[k] == 1) w1++; else w0++;
      end
    end
  endtask

  task automatic test_raw();
    set_req(1, 1'b1, 1'b1, 32'h20, 32'h12345678);
    @(negedge clk);
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL raw_wgrant: got %b expected 10", req_ready); end
    checks++; if (mem_wen !== 1'b1) begin errors++; $display("FAIL raw_wen_t0: got %b expected 1", mem_wen); end
    checks++; if (mem_waddr !== 32'h20) begin errors++; $display("FAIL raw_waddr: got %h expected 00000020", mem_waddr); end
    checks++; if (mem_wdata !== 32'h12345678) begin errors++; $display("FAIL raw_wdata: got %h expected 12345678", mem_wdata); end
    tick();
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(0, 1'b1, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    checks++; if (mem_wen !== 1'b0) begin errors++; $display("FAIL raw_wen_t1: got %b expected 0", mem_wen); end
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL raw_rgrant: got %b expected 01", req_ready); end
    tick();
    drive_idle();
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL raw_rsp_t2: got %b expected 00", rsp_valid); end
    tick();
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL raw_rsp_t3: got %b expected 01", rsp_valid); end
    checks++; if (rsp_data !== 32'h12345678) begin errors++; $display("FAIL raw_data_t3: got %h expected 12345678", rsp_data); end
    $display("raw 0x20: rsp_valid=%b data=%h", rsp_valid, rsp_data);
    tick();
  endtask

  task automatic test_kill();
    set_req(0, 1'b1, 1'b0, 32'h44, 32'h0);
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL kill_g0: got %b expected 01", req_ready); end
    tick();
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h84, 32'h0);
    req_kill = 2'b01;
    @(negedge clk);
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL kill_g1: got %b expected 10", req_ready); end
    tick();
    drive_idle();
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL kill_rsp_t2: got %b expected 00", rsp_valid); end
    checks++; if (rd_inflight !== 2'd1) begin errors++; $display("FAIL kill_inflight: got %0d expected 1", rd_inflight); end
    tick();
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL kill_rsp_t3: got %b expected 10", rsp_valid); end
    checks++; if (rsp_data !== fill(33, 32'h0)) begin errors++; $display("FAIL kill_data: got %h expected %h", rsp_data, fill(33, 32'h0)); end
    $display("kill: survivor rsp_valid=%b data=%h", rsp_valid, rsp_data);
    tick();
  endtask

  task automatic test_reset_midflight();
    set_req(0, 1'b1, 1'b0, 32'h48, 32'h0);
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mrst_g0: got %b expected 01", req_ready); end
    tick();
    rst_n = 1'b0;
    set_req(0, 1'b1, 1'b0, 32'h4C, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h8C, 32'h0);
    @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL mrst_ready: got %b expected 00", req_ready); end
    tick();
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL mrst_rsp_t2: got %b expected 00", rsp_valid); end
    checks++; if (rd_inflight !== 2'd0) begin errors++; $display("FAIL mrst_inflight: got %0d expected 0", rd_inflight); end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL mrst_rsp_t3: got %b expected 00", rsp_valid); end
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mrst_regrant: got %b expected 01", req_ready); end
    tick();
    drive_idle();
    @(negedge clk);
    checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL mrst_rsp_t4: got %b expected 00", rsp_valid); end
    tick();
    tick();
    tick();
  endtask

  typedef struct {
    int          id;
    logic [31:0] data;
    int          due;
  } exp_t;

  task automatic test_random();
    logic [31:0] ref_mem [256];
    exp_t        q [$];
    exp_t        keep [$];
    exp_t        e;
    logic        pv [NREQ];
    logic        pw [NREQ];
    logic [31:0] pa [NREQ];
    logic [31:0] pd [NREQ];
    logic [1:0]  exp_rdy, exp_rsp;
    logic [31:0] exp_raddr;
    int          g, prio;
    salt = $urandom;
    mem_init = 1'b1;
    rst_n = 1'b0;
    drive_idle();
    tick();
    mem_init = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = fill(i, salt);
    for (int i = 0; i < NREQ; i++) pv[i] = 1'b0;
    prio = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!pv[i] && $urandom_range(0, 9) < 6) begin
          pv[i] = 1'b1;
          pw[i] = 1'($urandom_range(0, 1));
          pa[i] = $urandom;
          pd[i] = $urandom;
        end
        set_req(i, pv[i], pw[i], pa[i], pd[i]);
        req_kill[i] = ($urandom_range(0, 11) == 0);
      end
      @(negedge clk);
      g         = rst_n ? pick(req_valid, prio) : -1;
      exp_rdy   = (g >= 0) ? (2'b01 << g) : 2'b00;
      exp_raddr = (g >= 0 && !pw[g]) ? pa[g] : 32'h0;
      checks++;
      if (req_ready !== exp_rdy) begin
        errors++; $display("FAIL rnd_ready@%0d: got %b expected %b", cyc, req_ready, exp_rdy);
      end
      checks++;
      if (mem_wen !== (g >= 0 && pw[g])) begin
        errors++; $display("FAIL rnd_wen@%0d: got %b expected %b", cyc, mem_wen, (g >= 0 && pw[g]));
      end
      if (g >= 0 && pw[g]) begin
        checks++;
        if (mem_waddr !== pa[g] || mem_wdata !== pd[g]) begin
          errors++; $display("FAIL rnd_write@%0d: got %h/%h expected %h/%h", cyc, mem_waddr, mem_wdata, pa[g], pd[g]);
        end
      end
      checks++;
      if (mem_raddr !== exp_raddr) begin
        errors++; $display("FAIL rnd_raddr@%0d: got %h expected %h", cyc, mem_raddr, exp_raddr);
      end
      exp_rsp = (q.size() > 0 && q[0].due == cyc) ? (2'b01 << q[0].id) : 2'b00;
      checks++;
      if (rsp_valid !== exp_rsp) begin
        errors++; $display("FAIL rnd_rsp@%0d: got %b expected %b", cyc, rsp_valid, exp_rsp);
      end
      if (exp_rsp != 2'b00) begin
        checks++;
        if (rsp_data !== q[0].data) begin
          errors++; $display("FAIL rnd_data@%0d: got %h expected %h", cyc, rsp_data, q[0].data);
        end
      end
      checks++;
      if (rd_inflight !== 2'(q.size())) begin
        errors++; $display("FAIL rnd_inflight@%0d: got %0d expected %0d", cyc, rd_inflight, q.size());
      end
      if (exp_rsp != 2'b00) void'(q.pop_front());
      if (!rst_n) begin
        q.delete();
        prio = 0;
      end else begin
        if (g >= 0) begin
          if (pw[g]) begin
            ref_mem[pa[g][9:2]] = pd[g];
            $display("txn %0d: req%0d write addr=%h data=%h", cyc, g, pa[g], pd[g]);
          end else begin
            e.id = g; e.data = ref_mem[pa[g][9:2]]; e.due = cyc + 2;
            q.push_back(e);
            $display("txn %0d: req%0d read addr=%h", cyc, g, pa[g]);
          end
          pv[g] = 1'b0;
          prio = (g + 1) % NREQ;
        end
        keep.delete();
        foreach (q[j]) begin
          if (((req_kill >> q[j].id) & 2'b01) == 2'b00) keep.push_back(q[j]);
        end
        q = keep;
      end
      tick();
    end
    rst_n = 1'b1;
    drive_idle();
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_kill  = '0;
    req_addr  = '0;
    req_wdata = '0;
    mem_init  = 1'b1;
    poke      = 1'b0;
    poke_idx  = '0;
    poke_val  = '0;
    salt      = '0;
    test_reset();
    test_read_latency();
    test_alternate();
    test_raw();
    test_kill();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
